// File: rtl/ssd_display_scheduler_if.sv
// Bundle between the three value sources and the display scheduler.
//   req                : per-source level request (held while the source wants the display)
//   low0..2 / high0..2 : per-source 16-bit values for the low and high 4 digits
//   grant              : one-hot current owner, zero when idle
//   switch_pulse       : one-cycle strobe on every change to a new non-zero owner
//   displayNumberLow/High : saturated values of the owner, feeding ssd_counter
// master = source side (drives requests and data), slave = scheduler.
interface ssd_display_scheduler_if;
  logic [2:0]  req;
  logic [15:0] low0, low1, low2;
  logic [15:0] high0, high1, high2;
  logic [2:0]  grant;
  logic        switch_pulse;
  logic [15:0] displayNumberLow;
  logic [15:0] displayNumberHigh;

  modport master (
    output req, low0, low1, low2, high0, high1, high2,
    input  grant, switch_pulse, displayNumberLow, displayNumberHigh
  );

  modport slave (
    input  req, low0, low1, low2, high0, high1, high2,
    output grant, switch_pulse, displayNumberLow, displayNumberHigh
  );
endinterface

// File: rtl/ssd_display_scheduler.sv
// Shares the 8-digit seven-segment display among three value sources.
// Sources are granted round-robin for a minimum dwell time; source 0 (alerts)
// may preempt the others. The owner's values are saturated to four decimal
// digits and registered onto the display outputs one cycle behind grant.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of ssd_display_scheduler_if (requests, data, grant,
//             switch_pulse, displayNumberLow/High)
module ssd_display_scheduler #(
  parameter int          DWELL_CYCLES = 50_000_000,
  parameter bit          PREEMPT_EN   = 1'b1,
  parameter logic [15:0] SAT_MAX      = 16'd9999
) (
  input  logic                     clk,
  input  logic                     reset_n,
  ssd_display_scheduler_if.slave   bus
);

  typedef enum logic {IDLE, SHOW} state_t;

  localparam logic [31:0] DWELL_RELOAD = 32'(DWELL_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic        pulse_q, pulse_d;
  logic [31:0] dwell_q, dwell_d;
  logic [1:0]  last_q, last_d;
  logic [15:0] disp_low_q, disp_low_d;
  logic [15:0] disp_high_q, disp_high_d;

  function automatic logic [15:0] sat(input logic [15:0] x);
    return (x > SAT_MAX) ? SAT_MAX : x;
  endfunction

  // First requester strictly after 'last' (wrapping mod 3); one-hot, zero if none.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int k = 1; k <= 3; k++) begin
      idx = 2'((int'(last) + k) % 3);
      if (res == '0 && r[idx]) res = 3'b001 << idx;
    end
    return res;
  endfunction

  function automatic logic [1:0] idx_of(input logic [2:0] g);
    return g[2] ? 2'd2 : (g[1] ? 2'd1 : 2'd0);
  endfunction

  logic [2:0] win;
  logic       owner_req;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    pulse_d     = 1'b0;
    dwell_d     = dwell_q;
    last_d      = last_q;
    disp_low_d  = disp_low_q;
    disp_high_d = disp_high_q;
    win         = '0;
    owner_req   = |(bus.req & grant_q);

    case (state_q)
      IDLE: begin
        if (bus.req != 3'b000) begin
          win = rr_pick(bus.req, last_q);
        end
      end
      default: begin
        if (!owner_req) begin
          // Owner gone: hand over to the next requester, or fall idle silently.
          win = rr_pick(bus.req, last_q);
          if (win == '0) begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (PREEMPT_EN && bus.req[0] && !grant_q[0]) begin
          win = 3'b001;
        end else if (dwell_q != '0) begin
          dwell_d = dwell_q - 32'd1;
        end else begin
          // Dwell expired: rotate only to a different requester, else renew.
          win = rr_pick(bus.req & ~grant_q, last_q);
          if (win == '0) dwell_d = DWELL_RELOAD;
        end
      end
    endcase

    if (win != '0) begin
      state_d = SHOW;
      grant_d = win;
      pulse_d = 1'b1;
      dwell_d = DWELL_RELOAD;
      last_d  = idx_of(win);
    end

    // Display follows the registered grant, so it lags grant by one cycle.
    case (grant_q)
      3'b001: begin disp_low_d = sat(bus.low0); disp_high_d = sat(bus.high0); end
      3'b010: begin disp_low_d = sat(bus.low1); disp_high_d = sat(bus.high1); end
      3'b100: begin disp_low_d = sat(bus.low2); disp_high_d = sat(bus.high2); end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      pulse_q     <= 1'b0;
      dwell_q     <= '0;
      last_q      <= 2'd2;
      disp_low_q  <= '0;
      disp_high_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      pulse_q     <= pulse_d;
      dwell_q     <= dwell_d;
      last_q      <= last_d;
      disp_low_q  <= disp_low_d;
      disp_high_q <= disp_high_d;
    end
  end

  assign bus.grant             = grant_q;
  assign bus.switch_pulse      = pulse_q;
  assign bus.displayNumberLow  = disp_low_q;
  assign bus.displayNumberHigh = disp_high_q;

endmodule

// File: tb/tb_ssd_display_scheduler.sv
// Testbench for ssd_display_scheduler with DWELL_CYCLES=4, PREEMPT_EN=1.
// Directed scenarios followed by random requests, all checked against a
// behavioural model that tracks owner index and remaining dwell as integers.
module tb_ssd_display_scheduler;

  localparam int DWELL = 4;
  localparam int SATV  = 9999;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  ssd_display_scheduler_if bus();

  ssd_display_scheduler #(
    .DWELL_CYCLES (DWELL),
    .PREEMPT_EN   (1'b1),
    .SAT_MAX      (16'd9999)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: owner index (-1 idle), last owner, cycles of dwell remaining.
  int m_owner, m_last, m_left, m_pulse, m_dl, m_dh;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int satf(input int x);
    return (x > SATV) ? SATV : x;
  endfunction

  function automatic int lowof(input int i);
    return (i == 0) ? int'(bus.low0) : (i == 1) ? int'(bus.low1) : int'(bus.low2);
  endfunction

  function automatic int highof(input int i);
    return (i == 0) ? int'(bus.high0) : (i == 1) ? int'(bus.high1) : int'(bus.high2);
  endfunction

  function automatic int rr(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++)
      if (r[(last + k) % 3]) return (last + k) % 3;
    return -1;
  endfunction

  task automatic m_reset();
    m_owner = -1; m_last = 2; m_left = 0; m_pulse = 0; m_dl = 0; m_dh = 0;
  endtask

  function automatic int m_grant();
    return (m_owner < 0) ? 0 : (1 << m_owner);
  endfunction

  task automatic compare_all(input string tag);
    chk({tag, ".grant"}, int'(bus.grant), m_grant());
    chk({tag, ".pulse"}, int'(bus.switch_pulse), m_pulse);
    chk({tag, ".low"},   int'(bus.displayNumberLow), m_dl);
    chk({tag, ".high"},  int'(bus.displayNumberHigh), m_dh);
  endtask

  // Advance one clock: model computes the post-edge view from pre-edge inputs.
  task automatic tick(input string tag);
    logic [2:0] r;
    int w, n_owner, n_last, n_left, n_pulse, n_dl, n_dh;
    r = bus.req;
    n_owner = m_owner; n_last = m_last; n_left = m_left; n_pulse = 0;
    n_dl = m_dl; n_dh = m_dh;
    if (m_owner >= 0) begin
      n_dl = satf(lowof(m_owner));
      n_dh = satf(highof(m_owner));
    end
    w = -1;
    if (m_owner < 0) begin
      w = rr(r, m_last);
    end else if (!r[m_owner]) begin
      w = rr(r, m_last);
      if (w < 0) n_owner = -1;
    end else if (r[0] && m_owner != 0) begin
      w = 0;
    end else if (m_left > 0) begin
      n_left = m_left - 1;
    end else begin
      logic [2:0] others;
      others = r;
      others[m_owner] = 1'b0;
      w = rr(others, m_last);
      if (w < 0) n_left = DWELL - 1;
    end
    if (w >= 0) begin
      n_owner = w; n_last = w; n_pulse = 1; n_left = DWELL - 1;
    end
    @(posedge clk);
    #1;
    m_owner = n_owner; m_last = n_last; m_left = n_left; m_pulse = n_pulse;
    m_dl = n_dl; m_dh = n_dh;
    compare_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    m_reset();
    compare_all("async_rst");
    @(posedge clk);
    #3;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.req = 3'b000;
    bus.low0 = 16'd11;  bus.high0 = 16'd22;
    bus.low1 = 16'd0;   bus.high1 = 16'd0;
    bus.low2 = 16'd333; bus.high2 = 16'd12000;
    m_reset();
    #22;
    compare_all("reset");
    reset_n = 1'b1;

    // Idle with no requests.
    for (int i = 0; i < 10; i++) tick("idle");
    chk("idle_grant", int'(bus.grant), 0);

    // Single requester with a value above the ceiling.
    bus.low1 = 16'd1234; bus.high1 = 16'd60000;
    bus.req = 3'b010;
    tick("grant1");
    chk("grant1_onehot", int'(bus.grant), 2);
    chk("grant1_pulse", int'(bus.switch_pulse), 1);
    tick("disp1");
    chk("disp1_low", int'(bus.displayNumberLow), 1234);
    chk("disp1_high", int'(bus.displayNumberHigh), 9999);
    for (int i = 0; i < 8; i++) tick("hold1");

    // Two requesters rotate every dwell period.
    do_reset();
    bus.req = 3'b110;
    tick("rot_first");
    chk("rot_first_grant", int'(bus.grant), 2);
    for (int i = 0; i < 14; i++) tick("rot");

    // Alert preempts src2 mid-dwell.
    bus.req = 3'b100;
    for (int i = 0; i < 6; i++) tick("to_src2");
    bus.req = 3'b101;
    tick("preempt");
    chk("preempt_grant", int'(bus.grant), 1);
    chk("preempt_pulse", int'(bus.switch_pulse), 1);
    for (int i = 0; i < 3; i++) tick("post_pre");

    // Owner src1 drops in favour of src2, then everything drops.
    bus.req = 3'b010;
    for (int i = 0; i < 3; i++) tick("to_src1");
    bus.req = 3'b100;
    tick("drop1");
    chk("drop1_grant", int'(bus.grant), 4);
    tick("drop1b");
    bus.req = 3'b000;
    tick("idle_again");
    chk("idle_again_pulse", int'(bus.switch_pulse), 0);
    for (int i = 0; i < 4; i++) tick("idle_hold");
    chk("idle_hold_high", int'(bus.displayNumberHigh), 9999);

    // Reset mid-dwell, restart with all requesting.
    bus.req = 3'b011;
    for (int i = 0; i < 2; i++) tick("pre_rst");
    do_reset();
    bus.req = 3'b111;
    tick("restart");
    chk("restart_grant", int'(bus.grant), 1);
    for (int i = 0; i < 12; i++) tick("all3");

    // Random requests and data.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        bus.low0  = 16'($urandom_range(0, 12000));
        bus.high1 = 16'($urandom);
        bus.low2  = 16'($urandom_range(9990, 10010));
      end
      if ($urandom_range(0, 2) == 0) begin
        bus.high0 = 16'($urandom);
        bus.low1  = 16'($urandom_range(0, 12000));
        bus.high2 = 16'($urandom_range(0, 65535));
      end
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
